// File: rtl/count_uart_tx.sv
// Converts a 4-bit count into an ASCII hex character and sends it as an 8N1 UART frame (8E1 when COUNT_UART_TX_PARITY_EN is defined).
// Latency: tx falls one cycle after acceptance; frame is 10*CLK_DIV cycles (11*CLK_DIV with parity). Backpressure: in_ready is low for the whole frame, and words offered meanwhile are ignored.
module count_uart_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("count_uart_tx: CLK_DIV must be in 2..65535");
    end

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

`ifdef COUNT_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  char_q, char_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        rdy_q, rdy_d;
    logic        bit_end;

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    assign bit_end = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            char_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // Outputs are registered: each branch sets the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        div_d   = bit_end ? 16'd0 : div_q + 16'd1;
        idx_d   = idx_q;
        char_d  = char_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                idx_d = '0;
                if (in_valid && rdy_q) begin
                    char_d  = hex_char(in_data);
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = char_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef COUNT_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^char_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = char_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef COUNT_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign in_ready = rdy_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx at CLK_DIV=4; decodes each frame and checks the full tx waveform.
module tb_count_uart_tx;

    localparam int CLK_DIV = 4;
`ifdef COUNT_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    count_uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [7:0] ch;
        bit         disturb;
        logic [3:0] alt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; waits for in_ready, presents the word and returns just after the accepting edge.
    task automatic send(input logic [3:0] d, output int waited);
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Samples every cycle of the frame, then the idle cycle after it; ends on a negedge.
    task automatic run_frame(input string nm, input logic [7:0] exp, input bit hold,
                             input bit disturb, input logic [3:0] alt, output logic par_got);
        logic [10:0] eb;
        logic [7:0]  got;
        int          wave_bad;
        int          rdy_low;
        eb       = '1;
        eb[0]    = 1'b0;
        eb[8:1]  = exp;
`ifdef COUNT_UART_TX_PARITY_EN
        eb[9]    = ^exp;
`endif
        got      = '0;
        par_got  = 1'b0;
        wave_bad = 0;
        rdy_low  = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) in_valid = 1'b0;
            if (disturb && k == 12) begin
                in_data  = alt;
                in_valid = 1'b1;
            end
            if (disturb && k == 13) in_valid = 1'b0;
            if (tx !== eb[k / CLK_DIV]) wave_bad++;
            if (in_ready === 1'b0 && busy === 1'b1) rdy_low++;
            if (k % CLK_DIV == 2) begin
                if (k / CLK_DIV >= 1 && k / CLK_DIV <= 8) got[k / CLK_DIV - 1] = tx;
                if (k / CLK_DIV == 9 && NBITS == 11) par_got = tx;
            end
        end
        check({nm, "_byte"}, {24'd0, got}, {24'd0, exp});
        check({nm, "_wave_errs"}, wave_bad, 0);
        check({nm, "_ready_low_cycles"}, rdy_low, FRAME);
        @(negedge clk);
        check({nm, "_idle"}, {29'd0, in_ready, busy, tx}, 32'b101);
    endtask

    initial begin
        int   w;
        int   toggles;
        logic par;

        vecs[0] = '{d: 4'h3, ch: 8'h33, disturb: 1'b0, alt: 4'h0};
        vecs[1] = '{d: 4'hA, ch: 8'h41, disturb: 1'b0, alt: 4'h0};
        vecs[2] = '{d: 4'hF, ch: 8'h46, disturb: 1'b0, alt: 4'h0};
        vecs[3] = '{d: 4'h9, ch: 8'h39, disturb: 1'b0, alt: 4'h0};
        vecs[4] = '{d: 4'h5, ch: 8'h35, disturb: 1'b1, alt: 4'hC};
        vecs[5] = '{d: 4'h7, ch: 8'h37, disturb: 1'b0, alt: 4'h0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        #1;
        check("reset_outputs", {29'd0, in_ready, busy, tx}, 32'b101);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, w);
            run_frame($sformatf("vec%0d", i), vecs[i].ch, 1'b0, vecs[i].disturb, vecs[i].alt, par);
        end

        // A word offered mid-frame must not start a frame once the line goes idle.
        toggles = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) toggles++;
        end
        check("no_frame_after_ignored_word", toggles, 0);

`ifdef COUNT_UART_TX_PARITY_EN
        send(4'h7, w);
        run_frame("par7", 8'h37, 1'b0, 1'b0, 4'h0, par);
        check("parity_0x37", {31'd0, par}, 32'd1);
        send(4'h0, w);
        run_frame("par0", 8'h30, 1'b0, 1'b0, 4'h0, par);
        check("parity_0x30", {31'd0, par}, 32'd0);
`endif

        // Back-to-back with in_valid held high.
        send(4'h0, w);
        run_frame("b2b0", 8'h30, 1'b1, 1'b0, 4'h0, par);
        send(4'h1, w);
        check("b2b_gap1", w, 0);
        run_frame("b2b1", 8'h31, 1'b1, 1'b0, 4'h0, par);
        send(4'h2, w);
        check("b2b_gap2", w, 0);
        run_frame("b2b2", 8'h32, 1'b0, 1'b0, 4'h0, par);

        // Reset while idle.
        reset = 1'b1;
        #1;
        check("reset_idle", {29'd0, in_ready, busy, tx}, 32'b101);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during DATA bit 0 of 0x30, where tx is low.
        send(4'h0, w);
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("pre_reset_tx_low", {30'd0, busy, tx}, 32'b10);
        reset = 1'b1;
        #1;
        check("reset_mid_data", {29'd0, in_ready, busy, tx}, 32'b101);
        @(negedge clk);
        reset = 1'b0;
        toggles = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) toggles++;
        end
        check("quiet_after_reset", toggles, 0);

        send(4'h4, w);
        run_frame("after_reset", 8'h34, 1'b0, 1'b0, 4'h0, par);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
